// File: rtl/matmul_nxn_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// matmul_nxn_seq
// Sequential N x N matrix multiplier, C = A * B, one multiply-accumulate per
// clock. Operands are loaded element by element into the internal arrays A and
// B. A start pulse runs N^3 MAC cycles that fill C. C is read back through a
// registered random-access port.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high; aborts a run, leaves A/B/C contents
//   we1/we2   write enables for A / B (IDLE only; both may be high together)
//   addr_pi   row-major element address for writes (row*N + col)
//   data_pi   write data
//   start     begins a multiplication when idle; ignored while busy
//   rd_addr   row-major result address
//   data_out  C[rd_addr], registered, one-cycle latency
//   busy      high from the cycle after start through the FINISH cycle
//   done      one-cycle pulse in the FINISH cycle
// -----------------------------------------------------------------------------
module matmul_nxn_seq #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(N),
  parameter bit SIGNED = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we1,
  input  logic                    we2,
  input  logic [2*$clog2(N)-1:0]  addr_pi,
  input  logic [DATA_W-1:0]       data_pi,
  input  logic                    start,
  input  logic [2*$clog2(N)-1:0]  rd_addr,
  output logic [ACC_W-1:0]        data_out,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = $clog2(N);
  localparam int NE = N*N;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  // Widens an operand to the accumulator width, honouring signedness.
  function automatic logic signed [ACC_W-1:0] ext_op(input logic [DATA_W-1:0] x);
    if (SIGNED)
      return ACC_W'($signed(x));
    else
      return $signed(ACC_W'(x));
  endfunction

  logic [DATA_W-1:0] a_q [NE];
  logic [DATA_W-1:0] b_q [NE];
  logic [ACC_W-1:0]  c_q [NE];

  state_t                   state_q, state_d;
  logic [IW-1:0]            i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  op_a, op_b, prod, sum;
  logic                     c_we;
  logic                     busy_q, done_q;
  logic [ACC_W-1:0]         dout_q;

  // Row-major addressing with N a power of two: {row, col} is row*N + col.
  assign op_a = ext_op(a_q[{i_q, k_q}]);
  assign op_b = ext_op(b_q[{k_q, j_q}]);
  assign prod = op_a * op_b;
  assign sum  = acc_q + prod;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    c_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COMPUTE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_COMPUTE: begin
        if (k_q == IW'(N-1)) begin
          // Last term of the dot product: commit it and restart the sum.
          c_we  = 1'b1;
          acc_d = '0;
          k_d   = '0;
          if (j_q == IW'(N-1)) begin
            j_d = '0;
            if (i_q == IW'(N-1)) begin
              i_d     = '0;
              state_d = S_FINISH;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + IW'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FINISH);
      // Reads the pre-edge contents, so a C element written this edge shows
      // up one edge later.
      dout_q  <= c_q[rd_addr];
    end
  end

  // Storage arrays carry no reset; writes are suppressed on a reset edge so
  // an aborted run cannot commit a partial sum.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_IDLE) begin
      if (we1) a_q[addr_pi] <= data_pi;
      if (we2) b_q[addr_pi] <= data_pi;
    end
    if (!reset && c_we) c_q[{i_q, j_q}] <= sum;
  end

  assign data_out = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_matmul_nxn_seq.sv
`timescale 1ns/1ps
module tb_matmul_nxn_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, we1, we2, start;
  logic [5:0]  addr, rd_addr;
  logic [15:0] data;
  int          dsel;
  int          errors = 0;
  int          checks = 0;

  logic [3:0]  w1_g, w2_g, st_g, bz, dn;
  logic [33:0] do0, do1;
  logic [16:0] do2;
  logic [18:0] do3;
  logic [63:0] cur_dout;
  logic        cur_busy, cur_done;

  logic [63:0] expc [64];
  int          ma [64];
  int          mb [64];
  int exp_s1 [16] = '{56, 62, 68, 74, 152, 174, 196, 218,
                      248, 286, 324, 362, 344, 398, 452, 506};

  always_comb begin
    for (int x = 0; x < 4; x++) begin
      w1_g[x] = we1 && (dsel == x);
      w2_g[x] = we2 && (dsel == x);
      st_g[x] = start && (dsel == x);
    end
  end

  always_comb begin
    cur_dout = 64'(do0);
    case (dsel)
      1: cur_dout = 64'(do1);
      2: cur_dout = 64'(do2);
      3: cur_dout = 64'(do3);
      default: cur_dout = 64'(do0);
    endcase
    cur_busy = bz[dsel[1:0]];
    cur_done = dn[dsel[1:0]];
  end

  matmul_nxn_seq #(.N(4), .DATA_W(16), .SIGNED(1'b0)) u_u4 (
    .clk(clk), .reset(reset), .we1(w1_g[0]), .we2(w2_g[0]), .addr_pi(addr[3:0]),
    .data_pi(data), .start(st_g[0]), .rd_addr(rd_addr[3:0]), .data_out(do0),
    .busy(bz[0]), .done(dn[0]));

  matmul_nxn_seq #(.N(4), .DATA_W(16), .SIGNED(1'b1)) u_s4 (
    .clk(clk), .reset(reset), .we1(w1_g[1]), .we2(w2_g[1]), .addr_pi(addr[3:0]),
    .data_pi(data), .start(st_g[1]), .rd_addr(rd_addr[3:0]), .data_out(do1),
    .busy(bz[1]), .done(dn[1]));

  matmul_nxn_seq #(.N(2), .DATA_W(8), .SIGNED(1'b0)) u_n2 (
    .clk(clk), .reset(reset), .we1(w1_g[2]), .we2(w2_g[2]), .addr_pi(addr[1:0]),
    .data_pi(data[7:0]), .start(st_g[2]), .rd_addr(rd_addr[1:0]), .data_out(do2),
    .busy(bz[2]), .done(dn[2]));

  matmul_nxn_seq #(.N(8), .DATA_W(8), .SIGNED(1'b1)) u_n8 (
    .clk(clk), .reset(reset), .we1(w1_g[3]), .we2(w2_g[3]), .addr_pi(addr[5:0]),
    .data_pi(data[7:0]), .start(st_g[3]), .rd_addr(rd_addr[5:0]), .data_out(do3),
    .busy(bz[3]), .done(dn[3]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic a_en, input logic b_en, input int a, input logic [15:0] d);
    we1 = a_en; we2 = b_en; addr = 6'(a); data = d;
    @(negedge clk);
    we1 = 1'b0; we2 = 1'b0;
  endtask

  task automatic rd(input int a, output logic [63:0] v);
    rd_addr = 6'(a);
    @(negedge clk);
    v = cur_dout;
  endtask

  task automatic chk_all(input string tag, input int ne);
    logic [63:0] v;
    for (int n = 0; n < ne; n++) begin
      rd(n, v);
      chk($sformatf("%s C[%0d]", tag, n), v, expc[n]);
    end
  endtask

  // Starts a run and watches a bounded window. lat counts edges from the one
  // that samples start up to the one that raises done. inj >= 0 injects a
  // write to A[0] plus a start pulse at that cycle of the compute.
  task automatic run(input int n3, input int inj, output int lat, output int bc, output int dc);
    lat = -1; bc = 0; dc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int m = 0; m < n3 + 6; m++) begin
      if (cur_busy) bc++;
      if (cur_done) begin
        dc++;
        if (lat < 0) lat = m + 1;
      end
      if (m == inj) begin
        we1 = 1'b1; addr = 6'd0; data = 16'h1234; start = 1'b1;
      end else if (m == inj + 1) begin
        we1 = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic load_s1();
    for (int n = 0; n < 16; n++) wr(1'b1, 1'b1, n, 16'(n));
    for (int n = 0; n < 16; n++) expc[n] = 64'(exp_s1[n]);
  endtask

  initial begin
    int lat, bc, dc, sum;
    logic [63:0] v;
    logic [18:0] t19;

    dsel = 0; reset = 1'b1; we1 = 1'b0; we2 = 1'b0; start = 1'b0;
    addr = '0; data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      dsel = d;
      #1;
      chk($sformatf("rst busy d%0d", d), 64'(cur_busy), 64'd0);
      chk($sformatf("rst done d%0d", d), 64'(cur_done), 64'd0);
      chk($sformatf("rst dout d%0d", d), cur_dout, 64'd0);
    end
    reset = 1'b0;
    dsel = 0;
    @(negedge clk);

    // Scenario 1: A[n]=B[n]=n, loaded through a dual write.
    load_s1();
    run(64, -1, lat, bc, dc);
    chk("s1 latency", 64'(lat), 64'd65);
    chk("s1 busy cycles", 64'(bc), 64'd65);
    chk("s1 done pulses", 64'(dc), 64'd1);
    chk_all("s1", 16);

    // Scenario 2: identity on either side.
    for (int n = 0; n < 16; n++) begin
      wr(1'b1, 1'b0, n, (n % 5 == 0) ? 16'd1 : 16'd0);
      wr(1'b0, 1'b1, n, 16'(n + 100));
      expc[n] = 64'(n + 100);
    end
    run(64, -1, lat, bc, dc);
    chk_all("s2 IxB", 16);
    for (int n = 0; n < 16; n++) begin
      wr(1'b1, 1'b0, n, 16'(n + 100));
      wr(1'b0, 1'b1, n, (n % 5 == 0) ? 16'd1 : 16'd0);
    end
    run(64, -1, lat, bc, dc);
    chk_all("s2 AxI", 16);

    // Scenario 3: extreme operands, unsigned then signed.
    for (int n = 0; n < 16; n++) begin
      wr(1'b1, 1'b1, n, 16'hFFFF);
      expc[n] = 64'h3_FFF8_0004;
    end
    run(64, -1, lat, bc, dc);
    chk_all("s3 unsigned max", 16);
    dsel = 1;
    for (int n = 0; n < 16; n++) begin
      wr(1'b1, 1'b0, n, 16'hFFFF);
      wr(1'b0, 1'b1, n, 16'h0001);
      expc[n] = 64'h3_FFFF_FFFC;
    end
    run(64, -1, lat, bc, dc);
    chk("s3 signed done", 64'(dc), 64'd1);
    chk_all("s3 signed -1x1", 16);

    // Scenario 4: write and start during compute are locked out.
    dsel = 0;
    load_s1();
    run(64, 10, lat, bc, dc);
    chk("s4 done pulses", 64'(dc), 64'd1);
    chk("s4 latency", 64'(lat), 64'd65);
    chk_all("s4 locked", 16);
    run(64, -1, lat, bc, dc);
    chk("s4 rerun done", 64'(dc), 64'd1);
    chk_all("s4 rerun", 16);

    // Scenario 5: reset mid-compute over a known C pattern (C[n]=n+100).
    for (int n = 0; n < 16; n++) begin
      wr(1'b1, 1'b0, n, (n % 5 == 0) ? 16'd1 : 16'd0);
      wr(1'b0, 1'b1, n, 16'(n + 100));
    end
    run(64, -1, lat, bc, dc);
    load_s1();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s5 busy after rst", 64'(cur_busy), 64'd0);
    chk("s5 done after rst", 64'(cur_done), 64'd0);
    chk("s5 dout after rst", cur_dout, 64'd0);
    dc = 0; bc = 0;
    for (int m = 0; m < 80; m++) begin
      if (cur_done) dc++;
      if (cur_busy) bc++;
      @(negedge clk);
    end
    chk("s5 no done", 64'(dc), 64'd0);
    chk("s5 no busy", 64'(bc), 64'd0);
    for (int n = 0; n < 5; n++) begin
      rd(n, v);
      chk($sformatf("s5 kept new C[%0d]", n), v, 64'(exp_s1[n]));
    end
    rd(5, v);
    chk("s5 kept old C[5]", v, 64'd105);
    rd(15, v);
    chk("s5 kept old C[15]", v, 64'd115);
    run(64, -1, lat, bc, dc);
    chk("s5 fresh latency", 64'(lat), 64'd65);
    chk_all("s5 fresh", 16);

    // Scenario 6a: N=2, unsigned 8-bit, random operands.
    dsel = 2;
    for (int n = 0; n < 4; n++) begin
      ma[n] = $urandom_range(0, 255);
      mb[n] = $urandom_range(0, 255);
      wr(1'b1, 1'b0, n, 16'(ma[n]));
      wr(1'b0, 1'b1, n, 16'(mb[n]));
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        sum = 0;
        for (int k = 0; k < 2; k++) sum += ma[i*2+k] * mb[k*2+j];
        expc[i*2+j] = 64'(sum);
      end
    run(8, -1, lat, bc, dc);
    chk("s6 N2 latency", 64'(lat), 64'd9);
    chk_all("s6 N2", 4);

    // Scenario 6b: N=8, signed 8-bit, random operands.
    dsel = 3;
    for (int n = 0; n < 64; n++) begin
      ma[n] = $urandom_range(0, 255);
      mb[n] = $urandom_range(0, 255);
      wr(1'b1, 1'b0, n, 16'(ma[n]));
      wr(1'b0, 1'b1, n, 16'(mb[n]));
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        sum = 0;
        for (int k = 0; k < 8; k++)
          sum += ((ma[i*8+k] > 127) ? ma[i*8+k] - 256 : ma[i*8+k]) *
                 ((mb[k*8+j] > 127) ? mb[k*8+j] - 256 : mb[k*8+j]);
        t19 = 19'(sum);
        expc[i*8+j] = 64'(t19);
      end
    run(512, -1, lat, bc, dc);
    chk("s6 N8 latency", 64'(lat), 64'd513);
    chk("s6 N8 done pulses", 64'(dc), 64'd1);
    chk_all("s6 N8", 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
